// File: rtl/module_lector_banco_registros_if.sv
// Valid/ready read-out bus between the register-bank reader and its consumer.
// The master side (consumer/controller) drives start, bank and ready; the
// slave side (the reader) drives the word, its index and the status flags.
interface module_lector_banco_registros_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                   start_i;
  logic [DEPTH*WIDTH-1:0] banco_i;
  logic                   ready_i;
  logic [WIDTH-1:0]       dato_o;
  logic                   valid_o;
  logic [IW-1:0]          indice_o;
  logic                   busy_o;
  logic                   done_o;

  modport master (
    output start_i, banco_i, ready_i,
    input  dato_o, valid_o, indice_o, busy_o, done_o
  );

  modport slave (
    input  start_i, banco_i, ready_i,
    output dato_o, valid_o, indice_o, busy_o, done_o
  );
endinterface

// File: rtl/module_lector_banco_registros.sv
// Register-bank reader: on start it snapshots the whole bank, then streams the
// words in index order over valid/ready and pulses done after the last beat.
// Outputs are decoded purely from registered state, so ready never reaches
// the outputs combinationally.
module module_lector_banco_registros #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  module_lector_banco_registros_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] IDX_ZERO = IW'(0);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [IW-1:0]          idx_r, idx_s;
  logic [DEPTH*WIDTH-1:0] snapshot_r, snapshot_s;

  // State, index and snapshot registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      idx_r      <= IDX_ZERO;
      snapshot_r <= '0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      snapshot_r <= snapshot_s;
    end
  end

  // Next-state logic: accept start only in IDLE, advance the index on each beat.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    snapshot_s = snapshot_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_i) begin
          snapshot_s = bus.banco_i;
          idx_s      = IDX_ZERO;
          state_s    = ST_SEND;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_SEND: begin
        // valid is always 1 in SEND, so ready alone qualifies a beat
        if (bus.ready_i) begin
          if (idx_r == IDX_LAST) begin
            idx_s   = IDX_ZERO;
            state_s = ST_DONE;
          end else begin
            idx_s   = idx_r + IDX_ONE;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = IDX_ZERO;
      end
    endcase
  end

  // Output decode from registered state; the word bus is zero outside SEND.
  always_comb begin
    bus.dato_o   = '0;
    bus.valid_o  = 1'b0;
    bus.indice_o = IDX_ZERO;
    bus.busy_o   = 1'b0;
    bus.done_o   = 1'b0;
    case (state_r)
      ST_SEND: begin
        bus.valid_o  = 1'b1;
        bus.busy_o   = 1'b1;
        bus.dato_o   = snapshot_r[int'(idx_r)*WIDTH +: WIDTH];
        bus.indice_o = idx_r;
      end
      ST_DONE: begin
        bus.done_o = 1'b1;
        bus.busy_o = 1'b1;
      end
      default: begin
        bus.valid_o = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_module_lector_banco_registros.sv
// Bench for the register-bank reader: a DEPTH=4 instance for the main scenarios
// and a DEPTH=3 instance for the non-power-of-two index range. Expected words
// are queued when a start is driven and popped on every accepted beat.
module tb_module_lector_banco_registros;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic [7:0] w;
    logic [1:0] i;
  } exp_t;

  exp_t sb[$];
  exp_t sb3[$];

  module_lector_banco_registros_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
  module_lector_banco_registros_if #(.WIDTH(8), .DEPTH(3)) bus3 ();

  module_lector_banco_registros #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .bus(bus4.slave)
  );
  module_lector_banco_registros #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .bus(bus3.slave)
  );

  always #5 clk = ~clk;

  // Drive a start pulse on the 4-deep reader (caller is at a negedge) and queue the expected words.
  task automatic kick(input logic [31:0] bank);
    logic [31:0] b;
    b = bank;
    bus4.banco_i = b;
    bus4.start_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.w = b[k*8 +: 8];
      e.i = 2'(k);
      sb.push_back(e);
    end
  endtask

  // Run the 4-deep reader for a cycle budget; ready pattern by mode, optional restart attempt.
  task automatic drain(input int mode, input int budget, input int restart_cyc,
                       output int beats, output int dones, output int busy_cnt,
                       output int first_valid, output int done_cyc);
    logic       pat [5];
    logic       r;
    logic       hold_pend;
    logic [7:0] hd;
    logic [1:0] hi;
    exp_t       e;
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    beats = 0; dones = 0; busy_cnt = 0; first_valid = 0; done_cyc = 0;
    hold_pend = 1'b0; hd = 8'h00; hi = 2'd0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      bus4.start_i = (c == restart_cyc);
      if (c == restart_cyc) bus4.banco_i = 32'h44332211;
      r = (mode == 0) ? 1'b1 : pat[(c-1) % 5];
      bus4.ready_i = r;
      if (bus4.busy_o) busy_cnt++;
      if (bus4.done_o) begin
        dones++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (bus4.valid_o && first_valid == 0) first_valid = c;
      if (hold_pend) begin
        total++;
        if (bus4.valid_o !== 1'b1 || bus4.dato_o !== hd || bus4.indice_o !== hi) begin
          bad++;
          $display("FAIL hold c=%0d got v=%b d=%h i=%0d want v=1 d=%h i=%0d",
                   c, bus4.valid_o, bus4.dato_o, bus4.indice_o, hd, hi);
        end
      end
      if (!bus4.valid_o) begin
        total++;
        if (bus4.dato_o !== 8'h00) begin
          bad++;
          $display("FAIL dato_idle c=%0d got %h want 00", c, bus4.dato_o);
        end
      end
      if (bus4.valid_o && r) begin
        beats++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL extra_beat c=%0d got d=%h i=%0d want none", c, bus4.dato_o, bus4.indice_o);
        end else begin
          e = sb.pop_front();
          if (bus4.dato_o !== e.w || bus4.indice_o !== e.i) begin
            bad++;
            $display("FAIL beat c=%0d got d=%h i=%0d want d=%h i=%0d",
                     c, bus4.dato_o, bus4.indice_o, e.w, e.i);
          end
        end
      end
      hold_pend = bus4.valid_o && !r;
      hd = bus4.dato_o;
      hi = bus4.indice_o;
    end
    bus4.start_i = 1'b0;
  endtask

  // T1: reset state of both instances, then ready without start must not produce valid.
  task automatic test_reset();
    rst = 1'b1;
    bus4.start_i = 1'b0; bus4.ready_i = 1'b0; bus4.banco_i = '0;
    bus3.start_i = 1'b0; bus3.ready_i = 1'b0; bus3.banco_i = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus4.dato_o, bus4.valid_o, bus4.indice_o, bus4.busy_o, bus4.done_o} !== 13'd0) begin
      bad++;
      $display("FAIL reset4 got d=%h v=%b i=%0d b=%b dn=%b want all 0",
               bus4.dato_o, bus4.valid_o, bus4.indice_o, bus4.busy_o, bus4.done_o);
    end
    total++;
    if ({bus3.dato_o, bus3.valid_o, bus3.indice_o, bus3.busy_o, bus3.done_o} !== 13'd0) begin
      bad++;
      $display("FAIL reset3 got d=%h v=%b i=%0d b=%b dn=%b want all 0",
               bus3.dato_o, bus3.valid_o, bus3.indice_o, bus3.busy_o, bus3.done_o);
    end
    rst = 1'b0;
    bus4.ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (bus4.valid_o !== 1'b0 || bus4.busy_o !== 1'b0) begin
        bad++;
        $display("FAIL idle_ready c=%0d got v=%b b=%b want v=0 b=0", c, bus4.valid_o, bus4.busy_o);
      end
    end
  endtask

  // Common end-of-run checks shared by the streaming scenarios.
  task automatic check_run(input string nm, input int beats, input int dones,
                           input int busy_cnt, input int want_busy);
    total++;
    if (beats !== 4 || dones !== 1 || sb.size() !== 0) begin
      bad++;
      $display("FAIL %s_count got beats=%0d dones=%0d left=%0d want 4 1 0", nm, beats, dones, sb.size());
    end
    total++;
    if (busy_cnt !== want_busy) begin
      bad++;
      $display("FAIL %s_busy got %0d want %0d", nm, busy_cnt, want_busy);
    end
    total++;
    if (bus4.valid_o !== 1'b0 || bus4.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_end got v=%b b=%b want 0 0", nm, bus4.valid_o, bus4.busy_o);
    end
  endtask

  // T2: full-rate stream with latency checks.
  task automatic test_stream();
    int beats, dones, busy_cnt, fv, dc;
    kick(32'hDDCCBBAA);
    drain(0, 8, 0, beats, dones, busy_cnt, fv, dc);
    check_run("stream", beats, dones, busy_cnt, 5);
    total++;
    if (fv !== 1 || dc !== 5) begin
      bad++;
      $display("FAIL stream_latency got first=%0d done=%0d want 1 5", fv, dc);
    end
  endtask

  // T3: backpressure with ready toggling 0,1,0,0,1.
  task automatic test_backpressure();
    int beats, dones, busy_cnt, fv, dc;
    kick(32'hDDCCBBAA);
    drain(1, 16, 0, beats, dones, busy_cnt, fv, dc);
    check_run("bp", beats, dones, busy_cnt, 11);
  endtask

  // T4: bank change plus second start during SEND must be ignored.
  task automatic test_restart_ignored();
    int beats, dones, busy_cnt, fv, dc;
    kick(32'hDDCCBBAA);
    drain(0, 12, 2, beats, dones, busy_cnt, fv, dc);
    check_run("restart", beats, dones, busy_cnt, 5);
  endtask

  // T5: reset after the second beat, then a fresh transfer from index 0.
  task automatic test_midreset();
    int   beats, dones, busy_cnt, fv, dc;
    exp_t e;
    kick(32'hDDCCBBAA);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      bus4.start_i = 1'b0;
      bus4.ready_i = 1'b1;
      total++;
      e = sb.pop_front();
      if (bus4.valid_o !== 1'b1 || bus4.dato_o !== e.w || bus4.indice_o !== e.i) begin
        bad++;
        $display("FAIL pre_reset c=%0d got v=%b d=%h i=%0d want v=1 d=%h i=%0d",
                 c, bus4.valid_o, bus4.dato_o, bus4.indice_o, e.w, e.i);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus4.valid_o !== 1'b0 || bus4.busy_o !== 1'b0 || bus4.done_o !== 1'b0 || bus4.indice_o !== 2'd0) begin
      bad++;
      $display("FAIL midreset got v=%b b=%b dn=%b i=%0d want 0 0 0 0",
               bus4.valid_o, bus4.busy_o, bus4.done_o, bus4.indice_o);
    end
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    kick(32'h44332211);
    drain(0, 8, 0, beats, dones, busy_cnt, fv, dc);
    check_run("after_reset", beats, dones, busy_cnt, 5);
  endtask

  // T6: DEPTH=3 instance runs indices 0,1,2 then done, never index 3.
  task automatic test_depth3();
    logic [23:0] b;
    exp_t        e;
    int          beats, dones, dc;
    b = 24'hC3B2A1;
    beats = 0; dones = 0; dc = 0;
    @(negedge clk);
    bus3.banco_i = b;
    bus3.start_i = 1'b1;
    bus3.ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.w = b[k*8 +: 8];
      e.i = 2'(k);
      sb3.push_back(e);
    end
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      bus3.start_i = 1'b0;
      if (bus3.done_o) begin
        dones++;
        if (dc == 0) dc = c;
      end
      total++;
      if (bus3.indice_o > 2'd2) begin
        bad++;
        $display("FAIL d3_range c=%0d got i=%0d want <=2", c, bus3.indice_o);
      end
      if (bus3.valid_o) begin
        beats++;
        total++;
        if (sb3.size() == 0) begin
          bad++;
          $display("FAIL d3_extra c=%0d got i=%0d want none", c, bus3.indice_o);
        end else begin
          e = sb3.pop_front();
          if (bus3.dato_o !== e.w || bus3.indice_o !== e.i) begin
            bad++;
            $display("FAIL d3_beat c=%0d got d=%h i=%0d want d=%h i=%0d",
                     c, bus3.dato_o, bus3.indice_o, e.w, e.i);
          end
        end
      end
    end
    total++;
    if (beats !== 3 || dones !== 1 || dc !== 4) begin
      bad++;
      $display("FAIL d3_count got beats=%0d dones=%0d done_c=%0d want 3 1 4", beats, dones, dc);
    end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_restart_ignored();
    test_midreset();
    test_depth3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
